rr_mux_4_1_arb: RTL and testbench
=================================

RR_MUX_4_1_ARB -- requirements
Module: rr_mux_4_1_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the data width of each requester and of the output.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port in_valid, input, 4 bits: per-requester valid; bit i = requester i.
REQ-005 The block SHALL have port in_data0..in_data3, input, WIDTH bits each: requester payloads.
REQ-006 The block SHALL have port in_ready, output, 4 bits: per-requester accept; one-hot or zero.
REQ-007 The block SHALL have port out_valid, output, 1 bit: output register holds a word.
REQ-008 The block SHALL have port out_ready, input, 1 bit: downstream accept.
REQ-009 The block SHALL have port out_data, output, WIDTH bits: selected payload, registered.
REQ-010 The block SHALL have port out_sel, output, 2 bits: index of the requester that produced out_data, registered; the 2-bit select a 4:1 mux stage consumes.

Function
REQ-011 The block SHALL hold a 2-bit priority pointer ptr; the requester at index ptr has highest priority, then ptr+1, ptr+2, ptr+3 (mod 4).
REQ-012 The block SHALL compute load = !out_valid || out_ready combinationally.
REQ-013 The block SHALL grant, when load=1, exactly one requester: the first asserted in_valid bit in pointer order; no grant when load=0 or in_valid=0.
REQ-014 The block SHALL drive in_ready = grant (combinational, one-hot or zero); a transfer on requester i occurs when in_valid[i] && in_ready[i].
REQ-015 The block SHALL, on a transfer from i, register out_data <= in_data{i}, out_sel <= i, out_valid <= 1 at the next edge (latency 1 cycle).
REQ-016 The block SHALL, on a transfer from i, update ptr <= i+1 mod 4; grant of 3 wraps ptr to 0.
REQ-017 The block SHALL, when load=1 and no transfer occurs, clear out_valid at the next edge and keep ptr, out_data and out_sel unchanged.
REQ-018 The block SHALL, when out_valid=1 and out_ready=0, hold out_valid, out_data, out_sel and ptr stable and drive in_ready=0.
REQ-019 The block SHALL sustain one transfer per cycle when out_ready=1 continuously (simultaneous drain and refill).
REQ-020 The block SHALL never grant a requester whose in_valid is 0, and in_ready SHALL NOT depend on in_data.

Reset
REQ-021 The block SHALL, while rst_n=0, force out_valid=0, out_data=0, out_sel=0 and ptr=0 asynchronously, with in_ready=0.
REQ-022 The block SHALL discard any word held in the output register when reset asserts mid-operation; no transfer completes in a cycle in which rst_n=0.
REQ-023 The block SHALL resume arbitration on the first rising edge after rst_n deasserts, with requester 0 at highest priority.

Configuration
REQ-024 The block SHALL, when macro RR_MUX_FAIR_EN is defined, use round-robin arbitration as in REQ-011 and REQ-016.
REQ-025 The block SHALL, when RR_MUX_FAIR_EN is not defined, use fixed priority (index 0 highest, 3 lowest), with ptr neither present nor updated; all other behaviour is unchanged.

Verification
REQ-026 The bench SHALL apply reset mid-stream with out_valid=1 and out_ready=0 and check out_valid=0, out_sel=0 and in_ready=0 immediately, with no edge required.
REQ-027 The bench SHALL, with RR_MUX_FAIR_EN defined, hold in_valid=4'b1111, in_dataN=N+1 and out_ready=1 for 6 cycles and check out_sel sequence 0,1,2,3,0,1 and out_data sequence 1,2,3,4,1,2.
REQ-028 The bench SHALL, without RR_MUX_FAIR_EN, apply the same stimulus and check out_sel=0 and out_data=1 every cycle.
REQ-029 The bench SHALL grant requester 2 (in_data2=4'hA), hold out_ready=0 for 3 cycles, then raise it, and check out_data=4'hA and out_sel=2 stable throughout, in_ready=0 during the stall, and exactly one output transfer.
REQ-030 The bench SHALL, with in_valid=4'b1000 and ptr=3, transfer once and check ptr wraps to 0; then with in_valid=4'b1001, check that requester 0 is granted.
REQ-031 The bench SHALL drop in_valid to 0 with out_valid=1 and out_ready=1 and check that out_valid=0 on the next cycle with out_data unchanged.

Source files
------------

// File: rtl/rr_mux_4_1_arb.sv
// rr_mux_4_1_arb: 4-requester arbiter feeding a registered 4:1 mux output
// stage with a valid/ready handshake on both sides.
// Optional feature: define RR_MUX_FAIR_EN for round-robin arbitration.
// When it is undefined, arbitration is fixed priority with index 0 highest.
module rr_mux_4_1_arb #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_valid,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel
);

  localparam int unsigned NREQ  = 4;
  localparam int unsigned SEL_W = 2;

  logic [SEL_W-1:0] base_c;
  logic [SEL_W-1:0] grant_idx_c;
  logic             grant_any_c;
  logic             load_c;
  logic             xfer_c;
  logic [WIDTH-1:0] grant_data_c;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_sel_q,   out_sel_d;

`ifdef RR_MUX_FAIR_EN
  logic [SEL_W-1:0] ptr_q, ptr_d;

  // Highest-priority requester index comes from the rotating pointer.
  assign base_c = ptr_q;
`else
  // Fixed priority: search always starts at requester 0.
  assign base_c = '0;
`endif

  // Find the first asserted valid in priority order starting at base_c.
  always_comb begin
    logic [SEL_W-1:0] idx;
    grant_idx_c = '0;
    grant_any_c = 1'b0;
    idx         = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      idx = base_c + SEL_W'(k);
      if (in_valid[idx]) begin
        grant_idx_c = idx;
        grant_any_c = 1'b1;
      end
    end
  end

  // Payload mux for the granted requester.
  always_comb begin
    grant_data_c = in_data0;
    case (grant_idx_c)
      2'd0:    grant_data_c = in_data0;
      2'd1:    grant_data_c = in_data1;
      2'd2:    grant_data_c = in_data2;
      default: grant_data_c = in_data3;
    endcase
  end

  // Output register can take a word when empty or being drained this cycle.
  assign load_c   = !out_valid_q || out_ready;
  // No transfer may complete while reset is asserted.
  assign xfer_c   = rst_n && load_c && grant_any_c;
  assign in_ready = xfer_c ? (NREQ'(1) << grant_idx_c) : '0;

  // Next-state for the output register (and pointer when fair).
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
`ifdef RR_MUX_FAIR_EN
    ptr_d       = ptr_q;
`endif
    if (xfer_c) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data_c;
      out_sel_d   = grant_idx_c;
`ifdef RR_MUX_FAIR_EN
      ptr_d       = grant_idx_c + SEL_W'(1);
`endif
    end else if (load_c) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
`ifdef RR_MUX_FAIR_EN
      ptr_q       <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
`ifdef RR_MUX_FAIR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_4_1_arb.sv
// Self-checking bench for rr_mux_4_1_arb: directed scenarios plus random
// traffic checked against a behavioural arbiter model.
module tb_rr_mux_4_1_arb;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic [3:0]       in_valid;
  logic [WIDTH-1:0] d [4];
  logic [3:0]       in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_sel;

  int n_cmp;
  int n_err;
  int out_xfers;

  // Reference model state
  int               m_ptr;
  logic             m_ov;
  logic [WIDTH-1:0] m_od;
  logic [1:0]       m_os;

  rr_mux_4_1_arb #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data0 (d[0]),
    .in_data1 (d[1]),
    .in_data2 (d[2]),
    .in_data3 (d[3]),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sel  (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected grant: first valid requester walking from the pointer, mod 4.
  function automatic logic [3:0] exp_grant(input logic rst, input logic [3:0] iv,
                                           input logic ordy);
    int i;
    if (!rst) return 4'b0000;
    if (m_ov && !ordy) return 4'b0000;
    for (int k = 0; k < 4; k++) begin
      i = (m_ptr + k) % 4;
      if (iv[i]) return 4'(1 << i);
    end
    return 4'b0000;
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    m_ov  = 1'b0;
    m_od  = '0;
    m_os  = 2'd0;
  endtask

  // One clock: drive inputs, check at the falling edge, advance the model.
  task automatic step(input logic [3:0] iv, input logic ordy);
    logic [3:0] g;
    int         idx;
    in_valid  = iv;
    out_ready = ordy;
    @(negedge clk);
    g = exp_grant(rst_n, iv, ordy);
    check("in_ready",  32'(in_ready),  32'(g));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("out_data",  32'(out_data),  32'(m_od));
    check("out_sel",   32'(out_sel),   32'(m_os));
    if (out_valid && ordy) out_xfers++;
    @(posedge clk);
    #1;
    if (g != 4'b0000) begin
      idx = 0;
      for (int k = 0; k < 4; k++) if (g[k]) idx = k;
      m_ov = 1'b1;
      m_od = d[idx];
      m_os = 2'(idx);
`ifdef RR_MUX_FAIR_EN
      m_ptr = (idx + 1) % 4;
`endif
    end else if (!m_ov || ordy) begin
      m_ov = 1'b0;
    end
  endtask

  initial begin
    int exp_sel [6];
    logic [WIDTH-1:0] held;
`ifdef RR_MUX_FAIR_EN
    exp_sel = '{0, 1, 2, 3, 0, 1};
`else
    exp_sel = '{0, 0, 0, 0, 0, 0};
`endif
    n_cmp = 0;
    n_err = 0;
    out_xfers = 0;
    model_reset();
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) d[i] = WIDTH'(i + 1);

    // Reset state, no edge needed
    #2;
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_sel",   32'(out_sel),   32'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // All requesters valid, continuous drain
    for (int c = 0; c < 6; c++) begin
      step(4'b1111, 1'b1);
      check("seq_sel",  32'(out_sel),  32'(exp_sel[c]));
      check("seq_data", 32'(out_data), 32'(exp_sel[c] + 1));
      check("seq_valid", 32'(out_valid), 32'd1);
    end

    // Requests drop while output drains: valid clears, data held
    held = out_data;
    step(4'b0000, 1'b1);
    check("drop_valid", 32'(out_valid), 32'd0);
    check("drop_data",  32'(out_data),  32'(held));

    // Grant requester 2, stall three cycles, then drain once
    d[2] = 4'hA;
    out_xfers = 0;
    step(4'b0100, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step(4'b0100, 1'b0);
      check("stall_data",  32'(out_data),  32'hA);
      check("stall_sel",   32'(out_sel),   32'd2);
      check("stall_ready", 32'(in_ready),  32'd0);
      check("stall_valid", 32'(out_valid), 32'd1);
    end
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    check("stall_xfers", 32'(out_xfers), 32'd1);

    // Requester 3 alone wraps the pointer; then 0 beats 3
    step(4'b1000, 1'b1);
    check("wrap_sel", 32'(out_sel), 32'd3);
    in_valid  = 4'b1001;
    out_ready = 1'b1;
    #1;
    check("wrap_grant0", 32'(in_ready), 32'b0001);
    step(4'b1001, 1'b1);
    check("wrap_sel0", 32'(out_sel), 32'd0);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) d[i] = WIDTH'($urandom);
      step(4'($urandom_range(0, 15)), ($urandom % 4) != 0);
    end

    // Mid-stream reset while stalled with a held word
    step(4'b1111, 1'b1);
    step(4'b1111, 1'b0);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sel",   32'(out_sel),   32'd0);
    check("mid_rst_data",  32'(out_data),  32'd0);
    check("mid_rst_ready", 32'(in_ready),  32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check("hold_rst_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) d[i] = WIDTH'(i + 1);
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #1;
    check("post_rst_grant", 32'(in_ready), 32'b0001);
    step(4'b1111, 1'b1);
    check("post_rst_sel", 32'(out_sel), 32'd0);

    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < 4; i++) d[i] = WIDTH'($urandom);
      step(4'($urandom_range(0, 15)), ($urandom % 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
